// File: rtl/irq_ctrl_pkg.sv
// ============================================================================
// irq_ctrl_pkg : register map, CTRL field positions, FSM encoding and fault
//                source ID offsets shared by the interrupt controller files.
// Revision     : 1.0
// ============================================================================
`default_nettype none

package irq_ctrl_pkg;

  localparam logic [2:0] C_ADDR_PENDING  = 3'd0;
  localparam logic [2:0] C_ADDR_ENABLE   = 3'd1;
  localparam logic [2:0] C_ADDR_TRIGGER  = 3'd2;
  localparam logic [2:0] C_ADDR_COMPLETE = 3'd3;
  localparam logic [2:0] C_ADDR_CTRL     = 3'd4;

  localparam int C_CTRL_GEN      = 0;
  localparam int C_CTRL_LAF_EN   = 1;
  localparam int C_CTRL_SAF_EN   = 2;
  localparam int C_CTRL_LAF_PEND = 8;
  localparam int C_CTRL_SAF_PEND = 9;

  // Fault sources sit directly above the external lines in the ID space.
  localparam int C_LAF_OFS = 0;
  localparam int C_SAF_OFS = 1;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } irq_state_t;

endpackage

`default_nettype wire

// File: rtl/irq_prio_sel.sv
// ============================================================================
// irq_prio_sel : combinational find-first-set over the selectable vector,
//                starting the search at i_base and wrapping around.
// Revision     : 1.0
// ============================================================================
`default_nettype none

module irq_prio_sel #(
  parameter int C_NUM   = 34,
  parameter int C_ID_SZ = 6
) (
  input  logic [C_NUM-1:0]   i_req,
  input  logic [C_ID_SZ-1:0] i_base,
  output logic               o_valid,
  output logic [C_ID_SZ-1:0] o_id
);

  localparam int C_IW = (C_NUM > 1) ? $clog2(C_NUM) : 1;

  always_comb begin : p_sel
    int idx;
    o_valid = 1'b0;
    o_id    = '0;
    idx     = 0;
    for (int k = 0; k < C_NUM; k++) begin
      idx = int'(i_base) + k;
      if (idx >= C_NUM) idx = idx - C_NUM;
      if (!o_valid && i_req[idx[C_IW-1:0]]) begin
        o_valid = 1'b1;
        o_id    = C_ID_SZ'(idx);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/irq_ctrl.sv
// ============================================================================
// irq_ctrl : hart interrupt controller with per-source gateway, register port
//            and a single request/claim interface to the vectoring controller.
//            Optional MERLIN_IRQ_ROUND_ROBIN_EN selects rotating priority.
// Revision : 1.0
// ============================================================================
`default_nettype none

module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int C_IRQV_SZ = 32,
  parameter int C_ID_SZ   = 6
) (
  input  logic                 clk_i,
  input  logic                 clk_en_i,
  input  logic                 resetb_i,
  input  logic [C_IRQV_SZ-1:0] irqv_i,
  input  logic                 lsq_laf_i,
  input  logic                 lsq_saf_i,
  input  logic                 reg_rd_i,
  input  logic                 reg_wr_i,
  input  logic [2:0]           reg_addr_i,
  input  logic [31:0]          reg_wdata_i,
  output logic [31:0]          reg_rdata_o,
  output logic                 hvec_irq_o,
  output logic [C_ID_SZ-1:0]   hvec_irq_id_o,
  input  logic                 hvec_irq_ack_i
);

  localparam int C_NS     = C_IRQV_SZ + 2;
  localparam int C_LAF_ID = C_IRQV_SZ + C_LAF_OFS;
  localparam int C_SAF_ID = C_IRQV_SZ + C_SAF_OFS;
  localparam logic [C_NS-1:0] C_ONE = C_NS'(1);

  logic [C_IRQV_SZ-1:0] r_sync1, r_sync2, r_sync3;
  logic [C_IRQV_SZ-1:0] r_enable, r_trigger;
  logic                 r_gen, r_laf_en, r_saf_en;
  logic [C_NS-1:0]      r_epend, r_insvc;
  irq_state_t           r_state;

  logic [C_NS-1:0]    w_rise, w_level, w_pend, w_en, w_selectable;
  logic [C_NS-1:0]    w_edge_mask, w_cur_mask, w_claim_mask, w_cmp_mask;
  logic               w_claim, w_cur_sel, w_cmp_wr;
  logic [C_ID_SZ-1:0] w_cmp_id, w_base, w_sel_id;
  logic               w_sel_valid;
  logic [31:0]        w_rdata;

  // Gateway: level sources follow the synced line, edge sources are sticky.
  assign w_edge_mask  = {2'b11, r_trigger};
  assign w_rise       = {lsq_saf_i, lsq_laf_i, r_sync2 & ~r_sync3 & r_trigger};
  assign w_level      = {2'b00, r_sync2 & ~r_trigger};
  assign w_pend       = r_epend | (w_level & ~r_insvc);
  assign w_en         = {r_saf_en, r_laf_en, r_enable};
  assign w_selectable = w_pend & w_en & ~r_insvc & {C_NS{r_gen}};

  assign w_cur_mask   = C_ONE << hvec_irq_id_o;
  assign w_cur_sel    = |(w_selectable & w_cur_mask);
  assign w_claim      = (r_state == ST_REQ) && hvec_irq_ack_i;
  assign w_claim_mask = w_claim ? w_cur_mask : '0;

  assign w_cmp_id   = reg_wdata_i[C_ID_SZ-1:0];
  assign w_cmp_wr   = reg_wr_i && (reg_addr_i == C_ADDR_COMPLETE) && (int'(w_cmp_id) < C_NS);
  assign w_cmp_mask = w_cmp_wr ? (C_ONE << w_cmp_id) : '0;

`ifdef MERLIN_IRQ_ROUND_ROBIN_EN
  logic [C_ID_SZ-1:0] r_last_id;

  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i)              r_last_id <= C_ID_SZ'(C_NS - 1);
    else if (clk_en_i && w_claim) r_last_id <= hvec_irq_id_o;
  end

  assign w_base = (int'(r_last_id) == C_NS - 1) ? '0 : r_last_id + C_ID_SZ'(1);
`else
  assign w_base = '0;
`endif

  irq_prio_sel #(
    .C_NUM   (C_NS),
    .C_ID_SZ (C_ID_SZ)
  ) u_prio_sel (
    .i_req   (w_selectable),
    .i_base  (w_base),
    .o_valid (w_sel_valid),
    .o_id    (w_sel_id)
  );

  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_sync3 <= '0;
      r_epend <= '0;
      r_insvc <= '0;
    end else if (clk_en_i) begin
      r_sync1 <= irqv_i;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      // Same-cycle edge beats the claim clear; same-cycle claim beats COMPLETE.
      r_epend <= ((r_epend & ~w_claim_mask) | w_rise) & w_edge_mask;
      r_insvc <= (r_insvc & ~w_cmp_mask) | w_claim_mask;
    end
  end

  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      r_enable  <= '0;
      r_trigger <= '0;
      r_gen     <= 1'b0;
      r_laf_en  <= 1'b0;
      r_saf_en  <= 1'b0;
    end else if (clk_en_i && reg_wr_i) begin
      case (reg_addr_i)
        C_ADDR_ENABLE:  r_enable  <= reg_wdata_i[C_IRQV_SZ-1:0];
        C_ADDR_TRIGGER: r_trigger <= reg_wdata_i[C_IRQV_SZ-1:0];
        C_ADDR_CTRL: begin
          r_gen    <= reg_wdata_i[C_CTRL_GEN];
          r_laf_en <= reg_wdata_i[C_CTRL_LAF_EN];
          r_saf_en <= reg_wdata_i[C_CTRL_SAF_EN];
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_rdata = '0;
    case (reg_addr_i)
      C_ADDR_PENDING: w_rdata[C_IRQV_SZ-1:0] = w_pend[C_IRQV_SZ-1:0];
      C_ADDR_ENABLE:  w_rdata[C_IRQV_SZ-1:0] = r_enable;
      C_ADDR_TRIGGER: w_rdata[C_IRQV_SZ-1:0] = r_trigger;
      C_ADDR_COMPLETE: begin
        w_rdata[31]          = hvec_irq_o;
        w_rdata[C_ID_SZ-1:0] = hvec_irq_id_o;
      end
      C_ADDR_CTRL: begin
        w_rdata[C_CTRL_GEN]      = r_gen;
        w_rdata[C_CTRL_LAF_EN]   = r_laf_en;
        w_rdata[C_CTRL_SAF_EN]   = r_saf_en;
        w_rdata[C_CTRL_LAF_PEND] = r_epend[C_LAF_ID];
        w_rdata[C_CTRL_SAF_PEND] = r_epend[C_SAF_ID];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i)                 reg_rdata_o <= '0;
    else if (clk_en_i && reg_rd_i) reg_rdata_o <= w_rdata;
  end

  // The latched ID stays frozen while requesting; ack takes precedence over withdraw.
  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      r_state       <= ST_IDLE;
      hvec_irq_o    <= 1'b0;
      hvec_irq_id_o <= '0;
    end else if (clk_en_i) begin
      case (r_state)
        ST_IDLE: begin
          if (w_sel_valid) begin
            r_state       <= ST_REQ;
            hvec_irq_o    <= 1'b1;
            hvec_irq_id_o <= w_sel_id;
          end
        end
        ST_REQ: begin
          if (hvec_irq_ack_i || !w_cur_sel) begin
            r_state    <= ST_IDLE;
            hvec_irq_o <= 1'b0;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          hvec_irq_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_irq_ctrl.sv
// ============================================================================
// tb_irq_ctrl : directed, table-driven bench for irq_ctrl.
// Revision    : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_irq_ctrl;

  localparam int N   = 32;
  localparam int IDW = 6;

  logic            clk = 1'b0;
  logic            clk_en = 1'b1;
  logic            resetb = 1'b0;
  logic [N-1:0]    irqv = '0;
  logic            laf = 1'b0, saf = 1'b0;
  logic            rd = 1'b0, wr = 1'b0;
  logic [2:0]      addr = '0;
  logic [31:0]     wdata = '0;
  logic [31:0]     rdata;
  logic            irq;
  logic [IDW-1:0]  id;
  logic            ack = 1'b0;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  irq_ctrl #(.C_IRQV_SZ(N), .C_ID_SZ(IDW)) dut (
    .clk_i          (clk),
    .clk_en_i       (clk_en),
    .resetb_i       (resetb),
    .irqv_i         (irqv),
    .lsq_laf_i      (laf),
    .lsq_saf_i      (saf),
    .reg_rd_i       (rd),
    .reg_wr_i       (wr),
    .reg_addr_i     (addr),
    .reg_wdata_i    (wdata),
    .reg_rdata_o    (rdata),
    .hvec_irq_o     (irq),
    .hvec_irq_id_o  (id),
    .hvec_irq_ack_i (ack)
  );

  typedef struct {
    logic        do_wr;
    logic [2:0]  a;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
  endtask

  // All tasks start and end just after a falling edge.
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic reg_write(input logic [2:0] a, input logic [31:0] d);
    wr = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic reg_read(input logic [2:0] a, output logic [31:0] d);
    rd = 1'b1; addr = a;
    @(negedge clk);
    rd = 1'b0;
    d = rdata;
  endtask

  task automatic do_ack();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  task automatic wait_irq(input string name, input int exp_id, input int max);
    int c = 0;
    while (!irq && c < max) begin
      @(negedge clk);
      c++;
    end
    chk({name, " req"}, 32'(irq), 32'd1);
    chk({name, " id"}, 32'(id), 32'(exp_id));
  endtask

  task automatic pulse(input int n);
    irqv[n] = 1'b1;
    cyc(2);
    irqv[n] = 1'b0;
    cyc(3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int          cnt;

    tbl[0]  = '{1'b0, 3'd0, 32'h0,          32'h0};
    tbl[1]  = '{1'b0, 3'd1, 32'h0,          32'h0};
    tbl[2]  = '{1'b0, 3'd2, 32'h0,          32'h0};
    tbl[3]  = '{1'b0, 3'd3, 32'h0,          32'h0};
    tbl[4]  = '{1'b0, 3'd4, 32'h0,          32'h0};
    tbl[5]  = '{1'b0, 3'd5, 32'h0,          32'h0};
    tbl[6]  = '{1'b1, 3'd1, 32'hA5A5_0F0F,  32'hA5A5_0F0F};
    tbl[7]  = '{1'b1, 3'd2, 32'h1234_5678,  32'h1234_5678};
    tbl[8]  = '{1'b1, 3'd4, 32'hFFFF_FFFF,  32'h0000_0007};
    tbl[9]  = '{1'b1, 3'd7, 32'hFFFF_FFFF,  32'h0};
    tbl[10] = '{1'b1, 3'd0, 32'hFFFF_FFFF,  32'h0};
    tbl[11] = '{1'b1, 3'd3, 32'h0000_0005,  32'h0};
    tbl[12] = '{1'b1, 3'd1, 32'h0,          32'h0};
    tbl[13] = '{1'b1, 3'd2, 32'h0,          32'h0};
    tbl[14] = '{1'b1, 3'd4, 32'h0,          32'h0};

    cyc(2);
    resetb = 1'b1;
    cyc(1);
    chk("reset irq", 32'(irq), 32'd0);
    chk("reset id", 32'(id), 32'd0);
    chk("reset rdata", rdata, 32'd0);

    for (int i = 0; i < 15; i++) begin
      if (tbl[i].do_wr) reg_write(tbl[i].a, tbl[i].d);
      reg_read(tbl[i].a, d);
      chk($sformatf("reg vec %0d", i), d, tbl[i].exp);
    end

    // Level source 3: latency, in-service masking, COMPLETE re-arm.
    reg_write(3'd1, 32'h8);
    reg_write(3'd4, 32'h1);
    irqv[3] = 1'b1;
    wait_irq("lvl3", 3, 3);
    do_ack();
    chk("lvl3 ack drop", 32'(irq), 32'd0);
    cyc(4);
    chk("lvl3 no rereq", 32'(irq), 32'd0);
    reg_read(3'd0, d);
    chk("lvl3 pending masked", d, 32'h0);
    reg_write(3'd3, 32'd3);
    chk("lvl3 cmp same cycle", 32'(irq), 32'd0);
    cyc(1);
    chk("lvl3 rereq", 32'(irq), 32'd1);
    chk("lvl3 rereq id", 32'(id), 32'd3);
    do_ack();
    irqv[3] = 1'b0;
    cyc(4);
    reg_write(3'd3, 32'd3);
    cyc(3);
    chk("lvl3 idle", 32'(irq), 32'd0);

    // Fixed priority between 2 and 5.
    reg_write(3'd1, 32'h24);
    irqv[2] = 1'b1;
    irqv[5] = 1'b1;
    wait_irq("prio first", 2, 4);
    do_ack();
    irqv[2] = 1'b0;
    wait_irq("prio second", 5, 3);
    do_ack();
    irqv[5] = 1'b0;
    cyc(4);
    reg_write(3'd3, 32'd2);
    reg_write(3'd3, 32'd5);
    cyc(3);
    chk("prio idle", 32'(irq), 32'd0);

    // Edge source 7: edges during service collapse into one pending.
    reg_write(3'd2, 32'h80);
    reg_write(3'd1, 32'h80);
    irqv[7] = 1'b1;
    cyc(2);
    irqv[7] = 1'b0;
    wait_irq("edge7", 7, 6);
    do_ack();
    chk("edge7 ack drop", 32'(irq), 32'd0);
    pulse(7);
    pulse(7);
    cyc(3);
    chk("edge7 held by S", 32'(irq), 32'd0);
    reg_read(3'd0, d);
    chk("edge7 pending", d, 32'h80);
    reg_write(3'd3, 32'd7);
    wait_irq("edge7 again", 7, 4);
    do_ack();
    reg_write(3'd3, 32'd7);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (irq) cnt++;
    end
    chk("edge7 exactly once", 32'(cnt), 32'd0);
    reg_read(3'd0, d);
    chk("edge7 pending clr", d, 32'h0);

    // Withdraw on disable, then ack racing the withdraw.
    reg_write(3'd2, 32'h0);
    reg_write(3'd1, 32'h10);
    irqv[4] = 1'b1;
    wait_irq("wd", 4, 4);
    reg_write(3'd1, 32'h0);
    cyc(1);
    chk("wd dropped", 32'(irq), 32'd0);
    reg_write(3'd1, 32'h10);
    wait_irq("wd reenable", 4, 4);
    wr = 1'b1; addr = 3'd1; wdata = 32'h0;
    @(negedge clk);
    wr = 1'b0; ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    chk("wd+ack drop", 32'(irq), 32'd0);
    reg_write(3'd1, 32'h10);
    cyc(3);
    chk("wd+ack S set", 32'(irq), 32'd0);
    reg_read(3'd0, d);
    chk("wd+ack pending masked", d, 32'h0);
    reg_write(3'd3, 32'd4);
    wait_irq("wd after cmp", 4, 3);
    do_ack();
    irqv[4] = 1'b0;
    cyc(4);
    reg_write(3'd3, 32'd4);
    reg_write(3'd1, 32'h0);

    // Store access fault, then asynchronous reset mid-request.
    reg_write(3'd4, 32'h7);
    saf = 1'b1;
    @(negedge clk);
    saf = 1'b0;
    wait_irq("saf", 33, 4);
    reg_read(3'd4, d);
    chk("saf ctrl", d, 32'h0000_0207);
    @(posedge clk);
    #2 resetb = 1'b0;
    #1;
    chk("async reset irq", 32'(irq), 32'd0);
    chk("async reset id", 32'(id), 32'd0);
    @(negedge clk);
    resetb = 1'b1;
    for (int a = 0; a < 5; a++) begin
      reg_read(3'(a), d);
      chk($sformatf("post reset reg %0d", a), d, 32'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
Hart interrupt controller between the external `irqv_i` lines and the hart vectoring/exception controller. It also takes the load/store queue imprecise fault pulses (load/store access fault) as two extra sources. Per source it provides synchronisation, a gateway, pending/enable/trigger state and priority selection, and presents one request to the vectoring controller. Software configures it through a small word-addressed register port.

Parameters:
C_IRQV_SZ, 32, number of external interrupt lines (1..32)
C_ID_SZ, 6, source ID width; 2**C_ID_SZ >= C_IRQV_SZ+2

Ports:
clk_i  in  1  core clock
clk_en_i  in  1  clock enable; gates every state update
resetb_i  in  1  reset; asynchronous, active-low
irqv_i  in  C_IRQV_SZ  external interrupt lines, asynchronous, active-high
lsq_laf_i  in  1  load access fault, one-cycle synchronous pulse
lsq_saf_i  in  1  store access fault, one-cycle synchronous pulse
reg_rd_i  in  1  register read strobe
reg_wr_i  in  1  register write strobe
reg_addr_i  in  3  word address
reg_wdata_i  in  32  write data
reg_rdata_o  out  32  read data, registered
hvec_irq_o  out  1  interrupt request to vectoring controller
hvec_irq_id_o  out  C_ID_SZ  ID of the requested source
hvec_irq_ack_i  in  1  claim; vectoring controller has taken the request

Behaviour:
- Source IDs: irqv_i[n] is ID n. LAF is ID C_IRQV_SZ. SAF is ID C_IRQV_SZ+1.
- irqv_i passes through a 2-flop synchroniser. Fault pulses are used directly.
- Registers, all 32-bit; unmapped reads return 0; unmapped writes are ignored:
  - 0 PENDING, read-only: bit n per irqv source.
  - 1 ENABLE, read/write: bit n per irqv source.
  - 2 TRIGGER, read/write: 1 = rising-edge, 0 = level.
  - 3 COMPLETE: write an ID in [C_ID_SZ-1:0]. Reads return {inreq, id} = {hvec_irq_o, hvec_irq_id_o} in [31] and [C_ID_SZ-1:0].
  - 4 CTRL: [0] global enable, [1] LAF enable, [2] SAF enable (read/write); [9:8] LAF/SAF pending (read-only).
- reg_rdata_o is valid the cycle after reg_rd_i and holds until the next read.
- Gateway, per source, with in-service bit S:
  - Level source: pending = synced level & ~S.
  - Edge source: a sticky pending bit is set by a rising edge, cleared by claim. An edge in the same cycle as the claim leaves it set. Edges while S=1 are recorded, but the source is not selectable until complete.
  - Faults are always edge-type sticky.
- Selectable = pending & enable & ~S & global enable. Fixed priority: lowest ID wins.
- FSM states:
  - IDLE: enter REQ when any source is selectable; latch the selected ID.
  - REQ: hvec_irq_o=1 and hvec_irq_id_o frozen. A higher-priority arrival does not preempt.
  - REQ with hvec_irq_ack_i: set S[id], clear that source's edge pending, return to IDLE. The next request may assert no earlier than 1 cycle after.
  - REQ with the latched source no longer selectable (disabled, or level dropped): withdraw to IDLE next cycle.
  - Ack and withdraw in the same cycle: ack wins.
- COMPLETE write of an ID with S=1 clears S. An ID with S=0, or out of range, is ignored. COMPLETE and claim of the same ID in the same cycle: claim takes effect, COMPLETE is ignored.
- Register writes to ENABLE/CTRL take effect for selection the following cycle.
- Reset values: all registers, sync flops, pending, S, FSM=IDLE, hvec_irq_o=0, hvec_irq_id_o=0, reg_rdata_o=0. Reset mid-REQ drops the request immediately (asynchronously).

Optional Feature:
MERLIN_IRQ_ROUND_ROBIN_EN
- Defined: selection is rotating. The search starts at the ID after the last claimed ID and wraps around; the pointer resets to the highest ID, so the first search starts at ID 0.
- Undefined: fixed lowest-ID priority; no pointer register.

Decomposition:
- Shared package/defines file `irq_ctrl_defs.v`: register address constants, CTRL field positions, FSM state encodings, and the LAF/SAF ID offsets.
- Sub-module `irq_prio_sel`: combinational find-first-set over the selectable vector, with an optional rotation base. Outputs valid and ID.

Test Plan:
- Reset; enable irqv[3] (level) and global enable; raise irqv_i[3] -> hvec_irq_o=1 with id=3 within 3 cycles (2 sync + 1). Ack -> irq_o drops. With line still high, no re-request until COMPLETE write of 3, then re-request 1 cycle later.
- Enable IDs 2 and 5, both asserted -> id=2 first. Ack, COMPLETE 2, deassert 2 -> id=5. With MERLIN_IRQ_ROUND_ROBIN_EN and both held high -> sequence 2, 5, 2.
- Edge trigger on ID 7: two pulses while S[7]=1 -> one pending recorded. After COMPLETE, exactly one further request with id=7.
- In REQ with id=4, clear ENABLE[4] -> hvec_irq_o=0 the next cycle. The same cycle with ack asserted -> claim accepted, S[4]=1.
- CTRL=0x7, lsq_saf_i pulse -> CTRL read [9]=1 and request id=33 (C_IRQV_SZ=32). Assert resetb_i low mid-REQ -> hvec_irq_o=0 immediately and all registers read 0.
